// File: rtl/seg7_pkg.sv
// Shared types, the hex segment table and polarity helpers for the seven-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StDrive
  } state_e;

  // Active-high abcdefg (bit 6 = a), listed from F down to 0 so the packed index equals the nibble.
  localparam logic [15:0][6:0] SegTable = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };

  function automatic logic [6:0] seg_off(input bit active_low);
    return active_low ? 7'h7f : 7'h00;
  endfunction

  function automatic logic [3:0] digit_off(input bit active_low);
    return {4{active_low}};
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Nibble to active-high abcdefg segment pattern; output polarity is applied by the parent.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SegTable[nibble_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with blanking gaps, frame-aligned shadow
// update behind a valid/ready load port, and optional leading-zero suppression.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES     = 1000,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic [15:0] data_in_i,
  input  logic [3:0]  dp_in_i,
  input  logic        lz_en_i,
  input  logic        load_i,
  output logic        ready_o,
  output logic [0:6]  seg_o,
  output logic        dp_o,
  output logic [3:0]  digit_o,
  output logic        frame_done_o
);

  localparam int unsigned    CntW         = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntLast      = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] CntBlankLast = CntW'(BLANK_CYCLES - 1);
  localparam state_e         StSlotStart  = (BLANK_CYCLES != 0) ? StBlank : StDrive;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [15:0]       pend_data_q, pend_data_d, shad_data_q, shad_data_d;
  logic [3:0]        pend_dp_q, pend_dp_d, shad_dp_q, shad_dp_d;
  logic              pend_valid_q, pend_valid_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        digit_q, digit_d;
  logic              frame_done_q, frame_done_d;

  logic              boundary, accept;
  logic [3:0]        cur_nib, nib_zero, lz_blank;
  logic [6:0]        seg_ah;

  // Counter runs 0..REFRESH_DIV-1 across a slot; BLANK owns the low counts, DRIVE the rest.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!enable_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StSlotStart;
          cnt_d   = '0;
          idx_d   = '0;
        end
        StBlank: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntBlankLast) state_d = StDrive;
        end
        StDrive: begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            state_d = StSlotStart;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign boundary     = (state_q == StDrive) && (idx_q == 2'd3) && (cnt_q == CntLast);
  assign accept       = load_i && !pend_valid_q;
  assign ready_o      = !pend_valid_q;
  assign frame_done_d = boundary && enable_i;

  // A load landing on the boundary edge skips pending so ready never drops.
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    shad_data_d  = shad_data_q;
    shad_dp_d    = shad_dp_q;
    if ((boundary || state_q == StIdle) && pend_valid_q) begin
      shad_data_d  = pend_data_q;
      shad_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    if (accept) begin
      if (boundary) begin
        shad_data_d = data_in_i;
        shad_dp_d   = dp_in_i;
      end else begin
        pend_data_d  = data_in_i;
        pend_dp_d    = dp_in_i;
        pend_valid_d = 1'b1;
      end
    end
  end

  assign cur_nib = shad_data_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .nibble_i (cur_nib),
    .seg_o    (seg_ah)
  );

  always_comb begin
    for (int k = 0; k < 4; k++) nib_zero[k] = (shad_data_q[4*k +: 4] == 4'h0);
    lz_blank[3] = nib_zero[3];
    lz_blank[2] = nib_zero[3] & nib_zero[2];
    lz_blank[1] = &nib_zero[3:1];
    lz_blank[0] = 1'b0;
  end

  // Gated by enable_i so a dropped enable turns the display off on the very next edge.
  always_comb begin
    seg_d   = seg_off(SEG_ACTIVE_LOW);
    dp_d    = SEG_ACTIVE_LOW;
    digit_d = digit_off(DIGIT_ACTIVE_LOW);
    if (enable_i && state_q == StDrive) begin
      digit_d = (4'b0001 << idx_q) ^ {4{DIGIT_ACTIVE_LOW}};
      if (!(lz_en_i && lz_blank[idx_q])) seg_d = seg_ah ^ {7{SEG_ACTIVE_LOW}};
      dp_d = shad_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      shad_data_q  <= '0;
      shad_dp_q    <= '0;
      seg_q        <= seg_off(SEG_ACTIVE_LOW);
      dp_q         <= SEG_ACTIVE_LOW;
      digit_q      <= digit_off(DIGIT_ACTIVE_LOW);
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      shad_data_q  <= shad_data_d;
      shad_dp_q    <= shad_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign digit_o      = digit_q;
  assign frame_done_o = frame_done_q;

endmodule
